// File: rtl/ucsbece154a_wbuf.sv
// ucsbece154a_wbuf -- store write buffer between the processor data port and
// data memory. Stores queue in a circular FIFO and retire in order whenever
// memory is ready. Loads read memory directly and take the youngest matching
// buffered store instead when one exists.
//
// Ports
//   clk, reset       rising-edge clock, synchronous active-high reset
//   we_i/a_i/wd_i    processor store request, address, data
//   rd_o             load data (combinational forward or mem_rd_i)
//   stall_o          store not accepted this cycle (buffer full)
//   mem_ra_o/rd_i    memory read port (address is a_i unchanged)
//   mem_we_o/wa_o/wd_o/ready_i  memory write port, driven from the head entry
//   count_o, empty_o occupancy

// Per-entry address comparator: one instance per buffer slot.
module ucsbece154a_wbuf_match (
  input  logic        valid,
  input  logic [29:0] ea,
  input  logic [29:0] a,
  output logic        hit
);
  assign hit = valid & (ea == a);
endmodule

module ucsbece154a_wbuf #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we_i,
  input  logic [31:0]              a_i,
  input  logic [31:0]              wd_i,
  output logic [31:0]              rd_o,
  output logic                     stall_o,
  output logic [31:0]              mem_ra_o,
  input  logic [31:0]              mem_rd_i,
  output logic                     mem_we_o,
  output logic [31:0]              mem_wa_o,
  output logic [31:0]              mem_wd_o,
  input  logic                     mem_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] wd;
  } entry_t;

  entry_t [DEPTH-1:0] buf_q;
  logic [PW-1:0]      head_q, tail_q;
  logic [CW-1:0]      cnt_q;
  logic               full, enq, deq;
  logic [DEPTH-1:0]   hit;
  logic [PW-1:0]      rd_ptr;

  // byte offset is ignored: the buffer works on word addresses only
  logic unused_lsb;
  assign unused_lsb = ^a_i[1:0];

  // full/stall use the registered count, so a drain in the same cycle does
  // not free room for the incoming store until the next cycle
  assign full    = (cnt_q == CW'(DEPTH));
  assign stall_o = we_i & full;
  assign enq     = we_i & ~full;
  assign deq     = mem_we_o & mem_ready_i;

  assign mem_we_o = (cnt_q != '0);
  assign mem_wa_o = {buf_q[head_q].wa, 2'b00};
  assign mem_wd_o = buf_q[head_q].wd;
  assign mem_ra_o = a_i;
  assign count_o  = cnt_q;
  assign empty_o  = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq) tail_q <= tail_q + 1'b1;
      if (deq) head_q <= head_q + 1'b1;
      case ({enq, deq})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // entry payload carries no reset; validity comes from head/count only
  always_ff @(posedge clk) begin
    if (enq) buf_q[tail_q] <= {a_i[31:2], wd_i};
  end

  // slot g is valid when its distance from head is below the count
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PW-1:0] age;
    logic          vld;
    assign age = PW'(g) - head_q;
    assign vld = ({1'b0, age} < cnt_q);
    ucsbece154a_wbuf_match u_match (
      .valid (vld),
      .ea    (buf_q[g].wa),
      .a     (a_i[31:2]),
      .hit   (hit[g])
    );
  end

  // walk oldest to youngest so the last hit (closest to tail) wins;
  // the head entry still forwards in the cycle it retires
  always_comb begin
    rd_o   = mem_rd_i;
    rd_ptr = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rd_ptr = head_q + PW'(i);
      if (hit[rd_ptr]) rd_o = buf_q[rd_ptr].wd;
    end
  end
endmodule

// File: tb/tb_ucsbece154a_wbuf.sv
module tb_ucsbece154a_wbuf;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, we_i, mem_ready_i;
  logic [31:0] a_i, wd_i, mem_rd_i;
  logic [31:0] rd_o, mem_ra_o, mem_wa_o, mem_wd_o;
  logic        stall_o, mem_we_o, empty_o;
  logic [$clog2(DEPTH):0] count_o;

  ucsbece154a_wbuf #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .we_i(we_i), .a_i(a_i), .wd_i(wd_i),
    .rd_o(rd_o), .stall_o(stall_o), .mem_ra_o(mem_ra_o), .mem_rd_i(mem_rd_i),
    .mem_we_o(mem_we_o), .mem_wa_o(mem_wa_o), .mem_wd_o(mem_wd_o),
    .mem_ready_i(mem_ready_i), .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // apply inputs after the falling edge, let combinational paths settle
  task automatic drive(input bit rst, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input bit rdy, input logic [31:0] rdi);
    @(negedge clk);
    reset = rst; we_i = we; a_i = a; wd_i = wd; mem_ready_i = rdy; mem_rd_i = rdi;
    #1;
  endtask

  typedef struct {
    bit rst; bit we; logic [31:0] a; logic [31:0] wd; bit rdy; logic [31:0] rdi;
    bit chk; bit stall; bit mwe; logic [31:0] wa; logic [31:0] wde; int cnt; logic [31:0] rd;
  } vec_t;
  vec_t tv[$];

  task automatic add(input bit rst, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input bit rdy, input logic [31:0] rdi, input bit chk, input bit stall,
                     input bit mwe, input logic [31:0] wa, input logic [31:0] wde,
                     input int cnt, input logic [31:0] rd);
    vec_t v;
    v.rst = rst; v.we = we; v.a = a; v.wd = wd; v.rdy = rdy; v.rdi = rdi;
    v.chk = chk; v.stall = stall; v.mwe = mwe; v.wa = wa; v.wde = wde; v.cnt = cnt; v.rd = rd;
    tv.push_back(v);
  endtask

  task automatic check_outs(input string tag, input bit stall, input bit mwe,
                            input logic [31:0] wa, input logic [31:0] wde,
                            input int cnt, input logic [31:0] rd, input logic [31:0] ra);
    cmp({tag, ".stall"}, 32'(stall_o), 32'(stall));
    cmp({tag, ".mem_we"}, 32'(mem_we_o), 32'(mwe));
    cmp({tag, ".count"}, 32'(count_o), 32'(cnt));
    cmp({tag, ".empty"}, 32'(empty_o), 32'(cnt == 0));
    cmp({tag, ".rd"}, rd_o, rd);
    cmp({tag, ".mem_ra"}, mem_ra_o, ra);
    if (mwe) begin
      cmp({tag, ".mem_wa"}, mem_wa_o, wa);
      cmp({tag, ".mem_wd"}, mem_wd_o, wde);
    end
  endtask

  // reference model: an ordered list of pending stores
  typedef struct { logic [29:0] wa; logic [31:0] wd; } st_t;
  st_t mq[$];

  initial begin
    int nwr;
    bit hold;
    bit r_rst, r_we, r_rdy;
    logic [31:0] r_a, r_wd, r_rdi, e_rd;
    bit e_full, e_mwe;

    reset = 1'b1; we_i = 1'b0; a_i = '0; wd_i = '0; mem_ready_i = 1'b0; mem_rd_i = '0;

    // rst we a wd rdy rdi | chk stall mwe wa wd cnt rd
    add(1,0,0,0,1,0,              0,0,0,0,0,0,0);
    add(1,1,0,5,1,'h11,           1,0,0,0,0,0,'h11);
    add(0,1,'h10,'hDEADBEEF,1,'h12, 1,0,0,0,0,0,'h12);
    add(0,0,'h10,0,1,'h13,        1,0,1,'h10,'hDEADBEEF,1,'hDEADBEEF);
    add(0,0,'h10,0,1,'h14,        1,0,0,0,0,0,'h14);
    add(0,1,'h0,'hA0,0,'h15,      1,0,0,0,0,0,'h15);
    add(0,1,'h4,'hA1,0,'h16,      1,0,1,'h0,'hA0,1,'h16);
    add(0,1,'h8,'hA2,0,'h17,      1,0,1,'h0,'hA0,2,'h17);
    add(0,1,'hC,'hA3,0,'h18,      1,0,1,'h0,'hA0,3,'h18);
    add(0,1,'h10,'hA4,0,'h19,     1,1,1,'h0,'hA0,4,'h19);
    add(0,1,'h10,'hA4,0,'h1A,     1,1,1,'h0,'hA0,4,'h1A);
    add(0,1,'h10,'hA4,1,'h1B,     1,1,1,'h0,'hA0,4,'h1B);
    add(0,1,'h10,'hA4,1,'h1C,     1,0,1,'h4,'hA1,3,'h1C);
    add(0,0,'h10,0,1,'h1D,        1,0,1,'h8,'hA2,3,'hA4);
    add(0,0,'h0,0,1,'h1E,         1,0,1,'hC,'hA3,2,'h1E);
    add(0,0,'h0,0,1,'h1F,         1,0,1,'h10,'hA4,1,'h1F);
    add(0,0,'h0,0,1,'h20,         1,0,0,0,0,0,'h20);
    add(0,1,'h20,1,0,'h21,        1,0,0,0,0,0,'h21);
    add(0,1,'h20,2,0,'h22,        1,0,1,'h20,1,1,1);
    add(0,0,'h20,0,0,'h66,        1,0,1,'h20,1,2,2);
    add(0,0,'h20,0,1,'h67,        1,0,1,'h20,1,2,2);
    add(0,0,'h20,0,1,'h68,        1,0,1,'h20,2,1,2);
    add(0,0,'h20,0,1,'h77,        1,0,0,0,0,0,'h77);
    add(0,1,'h24,9,0,'h23,        1,0,0,0,0,0,'h23);
    add(0,0,'h28,0,0,'h55,        1,0,1,'h24,9,1,'h55);
    add(0,0,'h26,0,0,'h56,        1,0,1,'h24,9,1,9);
    add(0,1,'h30,'hB0,0,'h57,     1,0,1,'h24,9,1,'h57);
    add(0,1,'h34,'hB1,0,'h58,     1,0,1,'h24,9,2,'h58);
    add(1,0,'h0,0,0,'h59,         1,0,1,'h24,9,3,'h59);
    add(0,0,'h0,0,1,'h5A,         1,0,0,0,0,0,'h5A);
    add(0,0,'h30,0,1,'h5B,        1,0,0,0,0,0,'h5B);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].we, tv[i].a, tv[i].wd, tv[i].rdy, tv[i].rdi);
      if (tv[i].chk)
        check_outs($sformatf("vec%0d", i), tv[i].stall, tv[i].mwe, tv[i].wa,
                   tv[i].wde, tv[i].cnt, tv[i].rd, tv[i].a);
    end

    // back-to-back enqueue and retire: count holds at 1, pointers wrap
    nwr = 0;
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 32'h100 + 32'(4*k), 32'hC000 + 32'(k), 1, 32'h0);
      check_outs($sformatf("wrap%0d", k), 0, k != 0, 32'h100 + 32'(4*(k-1)),
                 32'hC000 + 32'(k-1), (k == 0) ? 0 : 1, 32'h0, 32'h100 + 32'(4*k));
      if (mem_we_o && mem_ready_i) nwr++;
    end
    drive(0, 0, 32'h0, 32'h0, 1, 32'h0);
    check_outs("wrap_tail", 0, 1, 32'h124, 32'hC009, 1, 32'h0, 32'h0);
    if (mem_we_o && mem_ready_i) nwr++;
    drive(0, 0, 32'h0, 32'h0, 1, 32'h0);
    check_outs("wrap_done", 0, 0, 0, 0, 0, 32'h0, 32'h0);
    cmp("wrap.writes", 32'(nwr), 32'd10);

    // randomized traffic against the queue model
    drive(1, 0, 32'h0, 32'h0, 0, 32'h0);
    mq.delete();
    hold = 0;
    r_we = 0; r_a = '0; r_wd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        r_we = 1'($urandom_range(0, 1));
        r_a  = 32'h200 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
        r_wd = $urandom;
      end
      r_rdy = ($urandom_range(0, 3) < ((i < 700) ? 1 : 3));
      r_rst = ($urandom_range(0, 149) == 0);
      r_rdi = $urandom;
      drive(r_rst, r_we, r_a, r_wd, r_rdy, r_rdi);

      e_full = (mq.size() == DEPTH);
      e_mwe  = (mq.size() != 0);
      e_rd   = r_rdi;
      foreach (mq[j]) if (mq[j].wa == r_a[31:2]) e_rd = mq[j].wd;
      check_outs($sformatf("rnd%0d", i), r_we & e_full, e_mwe,
                 e_mwe ? {mq[0].wa, 2'b00} : 32'h0, e_mwe ? mq[0].wd : 32'h0,
                 mq.size(), e_rd, r_a);
      hold = r_we & e_full & !r_rst;

      @(posedge clk);
      if (r_rst) begin
        mq.delete();
        hold = 0;
      end else begin
        if (e_mwe && r_rdy) void'(mq.pop_front());
        if (r_we && !e_full) begin
          st_t s;
          s.wa = r_a[31:2];
          s.wd = r_wd;
          mq.push_back(s);
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ucsbece154a_wbuf.md
# ucsbece154a_wbuf

Store write buffer between the processor's data-memory port and the data memory. Stores from the processor are queued in a small FIFO and retired to memory in order whenever memory is ready, so a busy memory stalls the processor only when the buffer is full. Loads read memory directly and are forwarded from the youngest matching buffered store, so a load always returns the most recent stored value.

## Interface
- DEPTH, 4, number of buffer entries; must be a power of two and at least 2.
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- we_i  input  1  processor store request; this is the processor's MemWrite.
- a_i  input  32  processor data address; this is the ALU output.
- wd_i  input  32  processor store data.
- rd_o  output  32  load data to the processor; combinational.
- stall_o  output  1  the store this cycle is not accepted; the processor must hold we_i, a_i and wd_i.
- mem_ra_o  output  32  memory read address; always equal to a_i.
- mem_rd_i  input  32  memory read data; combinational from mem_ra_o.
- mem_we_o  output  1  memory write request.
- mem_wa_o  output  32  memory write address; the head entry's address.
- mem_wd_o  output  32  memory write data; the head entry's data.
- mem_ready_i  input  1  memory accepts the write this cycle.
- count_o  output  $clog2(DEPTH)+1  number of valid entries.
- empty_o  output  1  count_o == 0.

## Operation
- **Storage.**
  - Circular FIFO of DEPTH entries, each holding word address a[31:2] and 32-bit data.
  - Head pointer and tail pointer, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - Registered count, 0..DEPTH.
- **Addressing.** Word-aligned only. a_i[1:0] is ignored, and mem_wa_o[1:0] = 2'b00.
- **Enqueue.**
  - The buffer is full when count == DEPTH.
  - When we_i is high and the buffer is not full, {a_i[31:2], wd_i} is written at the tail and the tail advances.
  - stall_o = we_i & full. This is evaluated on the registered count, so a store is stalled even if a drain happens in the same cycle.
- **Drain.**
  - mem_we_o = (count != 0).
  - mem_wa_o and mem_wd_o always present the head entry.
  - The head retires at the clock edge when mem_we_o & mem_ready_i; the head then advances.
- **Count update.**
  - Enqueue only: count + 1.
  - Retire only: count − 1.
  - Both in the same cycle: count unchanged, and both pointers advance.
- **No coalescing.** Repeated stores to the same address occupy separate entries and retire in program order.
- **Load forwarding.**
  - Compare a_i[31:2] against every valid entry.
  - On any hit, rd_o is the data of the youngest matching entry, i.e. the one closest to the tail.
  - Otherwise rd_o = mem_rd_i.
  - An entry that retires this cycle still forwards this cycle.
  - The store being enqueued this cycle is not forwarded. The processor never stores and loads in the same cycle.
- **Reset.**
  - Count, head and tail are set to 0.
  - Entry contents are don't-care.
  - After reset: mem_we_o = 0, empty_o = 1, count_o = 0, and stall_o = 0 regardless of we_i.
  - Reset asserted mid-operation discards all pending stores; none are written to memory after the reset edge.

## Timing
- Enqueue has zero-cycle acceptance: a non-stalled store is captured at the next rising edge, and count_o reflects it one cycle later.
- Minimum store-to-memory latency is 1 cycle: with the buffer empty and mem_ready_i = 1, a store in cycle N has mem_we_o = 1 in cycle N+1 and is written at the end of N+1.
- Throughput is one retire per cycle while mem_ready_i = 1.
- rd_o, stall_o and mem_ra_o are purely combinational, with no added latency.
- mem_we_o, mem_wa_o and mem_wd_o depend only on registered state, so there is no combinational path from the processor inputs to the memory write port.
- While mem_ready_i = 0, mem_wa_o and mem_wd_o stay stable.

## Test plan
- **Reset then single store.**
  - Stimulus: store 0x10 ← 0xDEADBEEF with mem_ready_i = 1.
  - Required: the next cycle shows mem_we_o = 1, mem_wa_o = 0x10, mem_wd_o = 0xDEADBEEF; the cycle after shows empty_o = 1.
- **Fill while memory busy.**
  - Stimulus: mem_ready_i = 0; store to 0x0, 0x4, 0x8, 0xC, then 0x10.
  - Required: count_o reaches 4; the fifth store sees stall_o = 1 and holds.
  - Then raise mem_ready_i: entries retire in the order 0x0, 0x4, 0x8, 0xC; the fifth store is accepted one cycle after count drops to 3.
- **Forward youngest.**
  - Stimulus: mem_ready_i = 0; store 0x20 ← 1, then 0x20 ← 2, then load 0x20.
  - Required: rd_o = 2.
  - After both retire, rd_o = mem_rd_i.
- **Forward miss.**
  - Stimulus: buffer holds 0x24; load 0x28 with mem_rd_i = 0x55.
  - Required: rd_o = 0x55.
- **Simultaneous enqueue and retire, with wrap.**
  - Stimulus: mem_ready_i = 1 and continuous stores for 10 cycles.
  - Required: count_o stays 1; pointers wrap past DEPTH; memory sees all 10 writes in order.
- **Reset mid-operation.**
  - Stimulus: 3 pending stores with mem_ready_i = 0; assert reset for one cycle, then raise mem_ready_i.
  - Required: mem_we_o = 0 after reset, and no write reaches memory.
